phys_free_list: RTL
===================

// Module: phys_free_list
// PURPOSE
//  - Circular FIFO of unallocated physical-register tags for the renaming datapath.
//  - Sits directly downstream of the reorder buffer's retire outputs.
//    - Each retiring instruction's old tag (retire_told) returns here.
//  - Supplies up to N_WAY fresh destination tags per cycle to dispatch/rename.
//    - These become rob_packet_dis.tag.
// PARAMETERS
//  N_PREG     64        number of physical registers; power of two; also FIFO depth
//  N_ARCH     32        arch registers; phys tags 0..N_ARCH-1 are pre-mapped at reset
//  N_WAY      `N_WAY    superscalar width (dispatch and retire lanes)
//  TAG_BITS   `CDB_BITS tag width; must satisfy 2**TAG_BITS >= N_PREG
// PORTS
//  clock          in   1                   system clock
//  reset          in   1                   synchronous, active-high
//  alloc_req      in   N_WAY               per-lane tag request from dispatch; contiguous from lane 0
//  retire_valid   in   N_WAY               ROB retire lane valid
//  retire_told    in   N_WAY*TAG_BITS      ROB retired old tag per lane
//  free_tag       out  N_WAY*TAG_BITS      offered tag per lane (head+k)
//  free_valid     out  N_WAY               lane k offer is backed by a free tag
//  free_count     out  $clog2(N_PREG)+1    registered number of stored free tags
//  free_empty     out  1                   free_count==0
// BEHAVIOUR
//  - Reset values:
//    - entry[i] = N_ARCH+i for i < N_PREG-N_ARCH; remaining entries = 0.
//    - head=0, tail=N_PREG-N_ARCH (mod N_PREG), free_count=N_PREG-N_ARCH, free_empty=0.
//    - While reset is high: free_valid=0 and free_tag=0.
//  - Offer (combinational): free_tag[k] = entry[(head+k) mod N_PREG].
//    - free_valid[k] = (k < avail); avail = free_count when the bypass macro is off.
//  - Allocate: lane k pops iff alloc_req[k] && free_valid[k].
//    - Pops are in lane order; head advances by the pop count at posedge.
//    - Dispatch treats !free_valid[k] as a stall for lane k and above.
//  - Free: lane k pushes retire_told[k] iff retire_valid[k] && retire_told[k]!=0.
//    - Tag 0 is reserved and never enters the list.
//    - Pushes are compacted in lane order and written at tail..tail+n-1.
//    - tail advances by the push count.
//  - Count: free_count_next = free_count - pops + pushes, evaluated in one cycle.
//    - Simultaneous pop and push on the same cycle is legal.
//  - Wrap-around: head and tail are $clog2(N_PREG) bits and wrap naturally.
//    - Entries straddling index N_PREG-1 -> 0 are offered and written correctly.
//  - Empty: free_count==0 -> all free_valid=0 (without bypass); retire pushes still accepted.
//  - Full: free_count==N_PREG-1 max in legal operation (tag 0 never free).
//    - A push exceeding N_PREG is a double-free: protocol violation, flagged by assertion.
//    - On a double-free the count saturates at N_PREG.
//  - Reset mid-operation: all in-flight requests and retires in the reset cycle are dropped.
//    - State returns to the reset image on the next edge.
//  - Latency: a retired tag is offered the cycle after retire; alloc takes effect next cycle.
// CONFIGURATION
//  - FREE_LIST_BYPASS_EN defined:
//    - avail = free_count + pushes_this_cycle.
//    - Lanes k >= free_count take the (k-free_count)-th compacted retiring tag.
//    - Such a tag is not written to the FIFO if popped in the same cycle.
//    - Adds a combinational path retire_* -> free_tag/free_valid.
//  - FREE_LIST_BYPASS_EN undefined: no retire->offer path; one cycle free-to-reuse latency.
// STRUCTURE
//  - Shared package (sys_defs): `N_WAY, `CDB_BITS, `N_PREG, `N_ARCH, `SD.
//    - FREE_LIST_PACKET typedef {tag, valid} for the dispatch-side interface.
//  - Sub-module lane_compactor: N_WAY valid bits -> per-lane prefix offsets + popcount.
//    - Instantiated twice: retire pushes and alloc pops.
//  - Top: entry array, head/tail/count registers, offer muxes, assertions.
// TESTING  (N_PREG=64, N_ARCH=32, N_WAY=2)
//  1. Reset -> free_count=32, free_tag={33,32}, free_valid=2'b11, free_empty=0.
//  2. alloc_req=2'b11 one cycle -> next: free_count=30, free_tag={35,34}.
//  3. alloc_req=2'b11 for 16 cycles -> free_count=0, free_empty=1, free_valid=0.
//     - Then alloc_req=2'b01 -> no pop, count stays 0.
//  4. From empty, retire_valid=2'b11, told={0,5} -> next: count=1, free_tag[0]=5, free_valid=2'b01.
//  5. Drain/refill 3x across index 63->0 with a simultaneous alloc 2 + retire 2 each cycle.
//     - Count constant; tags returned in FIFO order; none lost or duplicated.
//  6. BYPASS_EN, count=0, retire told {9,7}, alloc_req=2'b11 same cycle.
//     - free_tag={9,7}, valid=2'b11; next count=0.
//     - Without macro: valid=0, next count=2.
//  7. Assert reset mid-drain (count=17) -> next cycle matches scenario 1 exactly.

Source files
------------

// File: rtl/phys_free_list_pkg.sv
// Shared renaming definitions (sys_defs slice) used by the physical-register free list.
// Optional feature macro: FREE_LIST_BYPASS_EN (retire-to-offer bypass in phys_free_list).
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif
`ifndef N_PREG
`define N_PREG 64
`endif
`ifndef N_ARCH
`define N_ARCH 32
`endif
`ifndef SD
`define SD
`endif

package phys_free_list_pkg;
  localparam int FL_N_WAY    = `N_WAY;
  localparam int FL_TAG_BITS = `CDB_BITS;
  localparam int FL_N_PREG   = `N_PREG;
  localparam int FL_N_ARCH   = `N_ARCH;

  typedef struct packed {
    logic [FL_TAG_BITS-1:0] tag;
    logic                   valid;
  } FREE_LIST_PACKET;
endpackage

// File: rtl/phys_free_list_lane_compactor.sv
// Turns a per-lane valid vector into exclusive prefix offsets and a population count,
// so valid lanes can be packed densely in lane order.
module lane_compactor #(
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  valid,
  output logic [CW-1:0] offset [N],
  output logic [CW-1:0] count
);
  always_comb begin
    count = '0;
    for (int k = 0; k < N; k++) begin
      offset[k] = count;
      count     = count + CW'(valid[k]);
    end
  end
endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical-register tags: retired old tags are pushed, up to N_WAY
// fresh tags are offered to rename each cycle. FREE_LIST_BYPASS_EN enables retire-to-offer bypass.
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int N_PREG   = FL_N_PREG,
  parameter int N_ARCH   = FL_N_ARCH,
  parameter int N_WAY    = FL_N_WAY,
  parameter int TAG_BITS = FL_TAG_BITS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_WAY-1:0]          alloc_req,
  input  logic [N_WAY-1:0]          retire_valid,
  input  logic [N_WAY*TAG_BITS-1:0] retire_told,
  output logic [N_WAY*TAG_BITS-1:0] free_tag,
  output logic [N_WAY-1:0]          free_valid,
  output logic [$clog2(N_PREG):0]   free_count,
  output logic                      free_empty
);
  localparam int PTR_W = $clog2(N_PREG);
  localparam int CNT_W = PTR_W + 1;
  localparam int LW    = $clog2(N_WAY + 1);

  logic [TAG_BITS-1:0] entry [N_PREG];
  logic [PTR_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count_q;

  logic [N_WAY-1:0]    push_v, pop_v, wr_en;
  logic [LW-1:0]       push_off [N_WAY];
  logic [LW-1:0]       pop_off  [N_WAY];
  logic [LW-1:0]       n_push, n_pop, fifo_pops, byp_used;
  logic [PTR_W-1:0]    wr_idx [N_WAY];
  logic [TAG_BITS-1:0] rd_tag;
  int                  avail;
  int                  count_raw;

  function automatic logic [CNT_W-1:0] sat_count(input int c);
    if (c > N_PREG) return CNT_W'(N_PREG);
    return CNT_W'(c);
  endfunction

  always_comb begin
    for (int k = 0; k < N_WAY; k++)
      push_v[k] = retire_valid[k] && (retire_told[k*TAG_BITS +: TAG_BITS] != '0);
  end

  lane_compactor #(.N(N_WAY), .CW(LW)) u_push_compact (
    .valid (push_v),
    .offset(push_off),
    .count (n_push)
  );

`ifdef FREE_LIST_BYPASS_EN
  logic [TAG_BITS-1:0] push_tag [N_WAY];

  // Retiring tags packed in lane order; the head of this list extends the FIFO contents.
  always_comb begin
    for (int j = 0; j < N_WAY; j++) begin
      push_tag[j] = '0;
      for (int k = 0; k < N_WAY; k++)
        if (push_v[k] && (push_off[k] == LW'(j)))
          push_tag[j] = retire_told[k*TAG_BITS +: TAG_BITS];
    end
  end
`endif

  always_comb begin
    avail = int'(count_q);
`ifdef FREE_LIST_BYPASS_EN
    avail = avail + int'(n_push);
`endif
    free_tag   = '0;
    free_valid = '0;
    rd_tag     = '0;
    for (int k = 0; k < N_WAY; k++) begin
      rd_tag = entry[head + PTR_W'(k)];
`ifdef FREE_LIST_BYPASS_EN
      for (int j = 0; j < N_WAY; j++)
        if (k == int'(count_q) + j) rd_tag = push_tag[j];
`endif
      if (!reset) begin
        free_tag[k*TAG_BITS +: TAG_BITS] = rd_tag;
        free_valid[k]                    = (k < avail);
      end
    end
  end

  assign pop_v = alloc_req & free_valid;

  lane_compactor #(.N(N_WAY), .CW(LW)) u_pop_compact (
    .valid (pop_v),
    .offset(pop_off),
    .count (n_pop)
  );

  // Pops beyond the stored count consume bypassed retire tags, which then skip the FIFO.
  always_comb begin
    fifo_pops = n_pop;
    if (int'(n_pop) > int'(count_q)) fifo_pops = LW'(count_q);
    byp_used  = n_pop - fifo_pops;
    count_raw = int'(count_q) - int'(n_pop) + int'(n_push);
    for (int k = 0; k < N_WAY; k++) begin
      wr_en[k]  = push_v[k] && (push_off[k] >= byp_used);
      wr_idx[k] = tail + PTR_W'(push_off[k] - byp_used);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= '0;
      tail    <= PTR_W'(N_PREG - N_ARCH);
      count_q <= CNT_W'(N_PREG - N_ARCH);
      for (int i = 0; i < N_PREG; i++)
        entry[i] <= (i < N_PREG - N_ARCH) ? TAG_BITS'(N_ARCH + i) : '0;
    end else begin
      head    <= head + PTR_W'(fifo_pops);
      tail    <= tail + PTR_W'(n_push - byp_used);
      count_q <= sat_count(count_raw);
      for (int k = 0; k < N_WAY; k++)
        if (wr_en[k]) entry[wr_idx[k]] <= retire_told[k*TAG_BITS +: TAG_BITS];
      assert (count_raw <= N_PREG)
        else $error("phys_free_list: double-free pushes count past N_PREG");
      for (int k = 0; k < N_WAY; k++)
        assert (!pop_v[k] || (int'(pop_off[k]) == k))
          else $error("phys_free_list: alloc_req not contiguous from lane 0");
    end
  end

  assign free_count = count_q;
  assign free_empty = (count_q == '0);
endmodule
